mem_stage_sram_controller: RTL

Memory-stage block of the ARM pipeline: consumes the EXE-to-MEM pipeline register outputs, performs 32-bit loads/stores against the board SRAM, and registers results into the MEM-to-WB pipeline register. The SRAM has a 16-bit data bus, so each word access is two multi-cycle half-word accesses under an FSM. While an access is in flight the block drops `ready`, and the hazard/freeze logic stalls all upstream stages.

---
 rtl/mem_stage_sram_controller_pkg.sv | 24 ++
 rtl/mem_stage_sram_controller_if.sv | 26 ++
 rtl/mem_stage_sram_controller_mem2wb.sv | 35 +++
 rtl/mem_stage_sram_controller.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_sram_controller_pkg.sv
// Shared types and constants for the MEM stage / SRAM controller slice.
package mem_stage_sram_controller_pkg;

  localparam int SRAM_ADDR_W       = 18;
  localparam int SRAM_DATA_W       = 16;
  localparam int DEFAULT_BASE_ADDR = 1024;

  // Access sequencer: IDLE -> LOW half -> HIGH half -> DONE -> IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte address -> SRAM word index (one word = two half-word locations)
  function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [31:0] byte_addr,
                                                         input logic [31:0] base);
    logic [31:0] off;
    off = byte_addr - base;
    return off[SRAM_ADDR_W:2];
  endfunction

endpackage

// File: rtl/mem_stage_sram_controller_if.sv
// Board SRAM bus: half-word address, split data in/out with pad drive enable, write strobe.
interface mem_stage_sram_controller_if;
  import mem_stage_sram_controller_pkg::*;

  logic [SRAM_ADDR_W-1:0] sramAddr;
  logic [SRAM_DATA_W-1:0] sramDqOut;
  logic                   sramDqOe;
  logic [SRAM_DATA_W-1:0] sramDqIn;
  logic                   sramWeN;

  modport master (
    output sramAddr,
    output sramDqOut,
    output sramDqOe,
    output sramWeN,
    input  sramDqIn
  );

  modport slave (
    input  sramAddr,
    input  sramDqOut,
    input  sramDqOe,
    input  sramWeN,
    output sramDqIn
  );
endinterface

// File: rtl/mem_stage_sram_controller_mem2wb.sv
// MEM-to-WB pipeline register: loads when enabled, holds otherwise, synchronous reset.
module RegisterUnitMEM2WB (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        writeBackEnIn,
  input  logic        memReadIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] memDataIn,
  input  logic [3:0]  destinationIn,
  output logic        writeBackEn,
  output logic        memRead,
  output logic [31:0] ALUResult,
  output logic [31:0] memData,
  output logic [3:0]  destination
);

  // Pipeline register with load enable
  always_ff @(posedge clk) begin
    if (rst) begin
      writeBackEn <= 1'b0;
      memRead     <= 1'b0;
      ALUResult   <= '0;
      memData     <= '0;
      destination <= '0;
    end else if (en) begin
      writeBackEn <= writeBackEnIn;
      memRead     <= memReadIn;
      ALUResult   <= ALUResultIn;
      memData     <= memDataIn;
      destination <= destinationIn;
    end
  end

endmodule

// File: rtl/mem_stage_sram_controller.sv
// MEM stage: 32-bit loads/stores as two multi-cycle half-word SRAM accesses,
// stalling upstream via ready while an access is in flight.
module mem_stage_sram_controller
  import mem_stage_sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        writeBackEnIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] storeDataIn,
  input  logic [3:0]  destinationIn,
  output logic        ready,
  output logic        writeBackEn,
  output logic        memRead,
  output logic [31:0] ALUResult,
  output logic [31:0] memData,
  output logic [3:0]  destination,
  mem_stage_sram_controller_if.master sram
);

  // A single wait cycle still needs a 1-bit counter
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  state_t                  state;
  logic [CNT_W-1:0]        waitCnt;
  logic [31:0]             rdBuf;

  logic                    memOp;
  logic                    isWrite;
  logic                    lastCycle;
  logic [SRAM_ADDR_W-2:0]  wordIdx;
  logic [31:0]             wbMemData;

  logic [SRAM_ADDR_W-1:0]  addrD;
  logic [SRAM_DATA_W-1:0]  dqOutD;
  logic                    dqOeD;
  logic                    weND;

  assign memOp     = memReadIn | memWriteIn;
  // Read wins when both are set, so no write strobe is ever issued for it
  assign isWrite   = memWriteIn & ~memReadIn;
  assign lastCycle = (waitCnt == LAST_CNT);
  assign wordIdx   = word_index(ALUResultIn, 32'(BASE_ADDR));

  // Access sequencer and read-data capture on the last cycle of each half
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      rdBuf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (memOp) state <= LOW;
        end
        LOW: begin
          if (lastCycle) begin
            if (!isWrite) rdBuf[15:0] <= sram.sramDqIn;
            waitCnt <= '0;
            state   <= HIGH;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (lastCycle) begin
            if (!isWrite) rdBuf[31:16] <= sram.sramDqIn;
            waitCnt <= '0;
            state   <= DONE;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        DONE: begin
          waitCnt <= '0;
          state   <= IDLE;
        end
        default: begin
          waitCnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // SRAM bus drive, decoded from state only so it is stable within a state
  always_comb begin
    addrD  = '0;
    dqOutD = '0;
    dqOeD  = 1'b0;
    weND   = 1'b1;
    case (state)
      LOW: begin
        addrD = {wordIdx, 1'b0};
        if (isWrite) begin
          dqOutD = storeDataIn[15:0];
          dqOeD  = 1'b1;
          weND   = 1'b0;
        end
      end
      HIGH: begin
        addrD = {wordIdx, 1'b1};
        if (isWrite) begin
          dqOutD = storeDataIn[31:16];
          dqOeD  = 1'b1;
          weND   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign sram.sramAddr  = addrD;
  assign sram.sramDqOut = dqOutD;
  assign sram.sramDqOe  = dqOeD;
  assign sram.sramWeN   = weND;

  // Stage handoff: free in IDLE for non-memory ops, and for one cycle in DONE
  always_comb begin
    ready = ((state == IDLE) && !memOp) || (state == DONE);
  end

  // Load data only reaches WB on a completed read; everything else carries 0
  always_comb begin
    wbMemData = ((state == DONE) && !isWrite) ? rdBuf : '0;
  end

  RegisterUnitMEM2WB u_mem2wb (
    .clk           (clk),
    .rst           (rst),
    .en            (ready),
    .writeBackEnIn (writeBackEnIn),
    .memReadIn     (memReadIn),
    .ALUResultIn   (ALUResultIn),
    .memDataIn     (wbMemData),
    .destinationIn (destinationIn),
    .writeBackEn   (writeBackEn),
    .memRead       (memRead),
    .ALUResult     (ALUResult),
    .memData       (memData),
    .destination   (destination)
  );

endmodule
